// File: rtl/dac_frame_feeder.sv
// Stereo sample FIFO feeding the I2S serializer. Generates BCLK/DACLRC from CLK and
// loads a new left/right word pair once per frame, emitting a silent frame on underrun.
module dac_frame_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int BCLK_DIV    = 4,
  parameter int BITS_PER_CH = 32
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [DATA_WIDTH-1:0]           in_left,
  input  logic [DATA_WIDTH-1:0]           in_right,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            BCLK,
  output logic                            DACLRC,
  output logic [DATA_WIDTH-1:0]           left_data,
  output logic [DATA_WIDTH-1:0]           right_data,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DCW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BCW = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(BCLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS_PER_CH - 1);
  localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);

  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic toggle;
  logic fall_evt;
  logic rise_evt;
  logic bit_last;
  logic load;
  logic fifo_empty;
  logic wr_en;
  logic pop;

  assign toggle     = (div_cnt == DIV_LAST);
  assign fall_evt   = toggle && BCLK;
  assign rise_evt   = toggle && !BCLK;
  assign bit_last   = (bit_cnt == BIT_LAST);
  // Last BCLK rise of the right slot: one BCLK half-period before DACLRC falls.
  assign load       = rise_evt && DACLRC && bit_last;

  assign fifo_empty = (fifo_level == '0);
  // Registered level only, so no path from in_valid to in_ready.
  assign in_ready   = (fifo_level != LVL_FULL);
  assign wr_en      = in_valid && in_ready;
  assign pop        = load && !fifo_empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      BCLK    <= 1'b0;
    end else if (toggle) begin
      div_cnt <= '0;
      BCLK    <= ~BCLK;
    end else begin
      div_cnt <= div_cnt + DCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt <= '0;
      DACLRC  <= 1'b0;
    end else if (fall_evt) begin
      if (bit_last) begin
        bit_cnt <= '0;
        DACLRC  <= ~DACLRC;
      end else begin
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A write landing in the load cycle of an empty FIFO is not bypassed: zeros go out.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      left_data  <= '0;
      right_data <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= load && fifo_empty;
      if (load) begin
        if (fifo_empty) begin
          left_data  <= '0;
          right_data <= '0;
        end else begin
          {left_data, right_data} <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_frame_feeder.sv
// Scoreboard bench for dac_frame_feeder: expected frames are queued by the stimulus and
// checked by a monitor at every DACLRC fall; a cycle model checks BCLK/DACLRC timing.
module tb_dac_frame_feeder;

  localparam int DW  = 16;
  localparam int FD  = 4;
  localparam int BD  = 2;
  localparam int BPC = 16;
  localparam int LW  = $clog2(FD) + 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          BCLK;
  logic          DACLRC;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  dac_frame_feeder #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BCLK_DIV(BD), .BITS_PER_CH(BPC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .BCLK(BCLK), .DACLRC(DACLRC),
    .left_data(left_data), .right_data(right_data), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          ur;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic at(input int n);
    while (cyc != n) @(negedge CLK);
  endtask

  task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic ur);
    frame_t f;
    f.l = l; f.r = r; f.ur = ur;
    exp_q.push_back(f);
  endtask

  // Present a pair for sampling at edge n; push it as an expected frame if it should be accepted.
  task automatic do_write(input int n, input logic [DW-1:0] l, input logic [DW-1:0] r, input bit push);
    at(n - 1);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    if (push) push_frame(l, r, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // BCLK/DACLRC against a free-running model of cycles since reset release.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        check("bclk",   32'(BCLK),   32'((cyc / BD) % 2));
        check("daclrc", 32'(DACLRC), 32'((cyc / (2 * BD * BPC)) % 2));
      end
    end
  end

  // Frame monitor: each DACLRC fall presents one completed load.
  initial begin
    frame_t f;
    logic prev_lrc;
    int ur_cnt;
    prev_lrc = 1'b0;
    ur_cnt   = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_lrc = 1'b0;
        ur_cnt   = 0;
      end else begin
        if (underrun) ur_cnt++;
        if (prev_lrc && !DACLRC) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame at cyc %0d: got %0h/%0h expected no frame", cyc, left_data, right_data);
          end else begin
            f = exp_q.pop_front();
            check("frame_left",  32'(left_data),  32'(f.l));
            check("frame_right", 32'(right_data), 32'(f.r));
            check("frame_underrun_pulses", 32'(ur_cnt), f.ur ? 32'd1 : 32'd0);
          end
          ur_cnt = 0;
        end
        prev_lrc = DACLRC;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_bclk",   32'(BCLK),       32'd0);
    check("rst_daclrc", 32'(DACLRC),     32'd0);
    check("rst_left",   32'(left_data),  32'd0);
    check("rst_right",  32'(right_data), 32'd0);
    check("rst_level",  32'(fifo_level), 32'd0);
    check("rst_ready",  32'(in_ready),   32'd1);
    check("rst_ur",     32'(underrun),   32'd0);
    push_frame('0, '0, 1'b1);   // load at 126
    push_frame('0, '0, 1'b1);   // load at 254
    #1 RST_N = 1'b1;

    // Two pairs before the load at 382
    do_write(260, 16'hA5A5, 16'h5A5A, 1'b1);
    do_write(261, 16'h1234, 16'h8001, 1'b1);
    at(261);
    check("level_two", 32'(fifo_level), 32'd2);

    // Burst of five into an empty FIFO: fifth is dropped
    for (int i = 0; i < 5; i++)
      do_write(520 + i, 16'h1111 * 16'(i + 1), 16'hEEEE - 16'h1111 * 16'(i), i < 4);
    at(524);
    check("burst_level", 32'(fifo_level), 32'd4);
    check("burst_ready", 32'(in_ready),   32'd0);
    at(637);
    check("pre_pop_level", 32'(fifo_level), 32'd4);
    at(638);
    check("post_pop_level", 32'(fifo_level), 32'd3);
    check("post_pop_ready", 32'(in_ready),   32'd1);

    // Refill to full, then write in the load cycle: ignored, one pop
    do_write(640, 16'h6666, 16'h9999, 1'b1);
    at(765);
    check("full_before_load", 32'(fifo_level), 32'd4);
    do_write(766, 16'h7777, 16'h8888, 1'b0);
    check("full_load_level", 32'(fifo_level), 32'd3);

    // FIFO drains by 1150; write into empty in the 1278 load cycle
    at(1270);
    check("drained_level", 32'(fifo_level), 32'd0);
    push_frame('0, '0, 1'b1);
    do_write(1278, 16'h0F0F, 16'hF0F0, 1'b1);
    check("empty_load_level", 32'(fifo_level), 32'd1);

    // Queue three, then reset in the middle of the right slot
    do_write(1410, 16'hC0DE, 16'h0001, 1'b0);
    do_write(1411, 16'hC0DE, 16'h0002, 1'b0);
    do_write(1412, 16'hC0DE, 16'h0003, 1'b0);
    check("queued_level", 32'(fifo_level), 32'd3);
    at(1480);
    check("mid_right_slot", 32'(DACLRC), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("arst_bclk",   32'(BCLK),       32'd0);
    check("arst_daclrc", 32'(DACLRC),     32'd0);
    check("arst_left",   32'(left_data),  32'd0);
    check("arst_right",  32'(right_data), 32'd0);
    check("arst_level",  32'(fifo_level), 32'd0);
    check("arst_ready",  32'(in_ready),   32'd1);
    check("arst_ur",     32'(underrun),   32'd0);
    check("queue_drained_at_reset", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge CLK);
    push_frame('0, '0, 1'b1);
    push_frame('0, '0, 1'b1);
    #1 RST_N = 1'b1;
    at(260);
    check("post_reset_level", 32'(fifo_level), 32'd0);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
